// File: rtl/syncbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syncbus_pkg
// Description : Shared types, defaults and helpers for the sync bus master.
// Revision    : 1.0 - initial release
// ============================================================================
package syncbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

    // Lowest bit of read-data lane idx on a packed per-slave bus.
    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/syncbus_decode.sv
`default_nettype none
// ============================================================================
// Module      : syncbus_decode
// Description : Masked address compare against NSLV bases; lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module syncbus_decode
    import syncbus_pkg::*;
#(
    parameter int              AW       = 16,
    parameter int              NSLV     = 2,
    parameter logic [NSLV*AW-1:0] BASE  = {16'hFFF8, 16'hFFF0},
    parameter logic [AW-1:0]   DEC_MASK = 16'hFFF8,
    parameter int              IW       = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic [AW-1:0]   addr_i,
    output logic [IW-1:0]   idx_o,
    output logic [NSLV-1:0] sel_o,
    output logic            miss_o
);

    logic [NSLV-1:0] w_match;

    for (genvar i = 0; i < NSLV; i++) begin : g_match
        assign w_match[i] = ((addr_i & DEC_MASK) == (BASE[i*AW +: AW] & DEC_MASK));
    end

    // Isolating the lowest set bit gives lowest-index priority for free.
    assign sel_o  = w_match & (~w_match + NSLV'(1));
    assign miss_o = ~|w_match;

    for (genvar b = 0; b < IW; b++) begin : g_idx
        logic [NSLV-1:0] w_m;
        for (genvar i = 0; i < NSLV; i++) begin : g_bit
            if (((i >> b) & 1) == 1) begin : g_on
                assign w_m[i] = sel_o[i];
            end else begin : g_off
                assign w_m[i] = 1'b0;
            end
        end
        assign idx_o[b] = |w_m;
    end

endmodule
`default_nettype wire

// File: rtl/syncbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : syncbus_ctrl
// Description : Single-request sync bus master with one-hot selects, per-slave
//               ack/read lanes, wait states and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module syncbus_ctrl
    import syncbus_pkg::*;
#(
    parameter int                 AW       = 16,
    parameter int                 DW       = 16,
    parameter int                 NSLV     = 2,
    parameter logic [NSLV*AW-1:0] BASE     = {16'hFFF8, 16'hFFF0},
    parameter logic [AW-1:0]      DEC_MASK = 16'hFFF8,
    parameter int                 TIMEOUT  = 16,
    parameter logic [63:0]        ERR_DATA = 64'(DEF_ERR_DATA)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
    output logic               resp_valid,
    output logic [DW-1:0]      resp_rdata,
    output logic               resp_err,
    output logic [AW-1:0]      bus_addr,
    output logic [DW-1:0]      bus_wdata,
    output logic               bus_w,
    output logic [NSLV-1:0]    bus_sel,
    input  logic [NSLV*DW-1:0] bus_rdata,
    input  logic [NSLV-1:0]    bus_ack
);

    localparam int            IW        = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] c_ERR     = DW'(ERR_DATA);

    logic [IW-1:0]   w_idx;
    logic [NSLV-1:0] w_sel;
    logic            w_miss;
    logic [DW-1:0]   w_lane [NSLV];

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            miss_q;
    logic            write_q;
    logic [CW-1:0]   cnt_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [DW-1:0]   resp_rdata_q;
    logic [AW-1:0]   bus_addr_q;
    logic [DW-1:0]   bus_wdata_q;
    logic            bus_w_q;
    logic [NSLV-1:0] bus_sel_q;

    syncbus_decode #(
        .AW       (AW),
        .NSLV     (NSLV),
        .BASE     (BASE),
        .DEC_MASK (DEC_MASK),
        .IW       (IW)
    ) u_decode (
        .addr_i (req_addr),
        .idx_o  (w_idx),
        .sel_o  (w_sel),
        .miss_o (w_miss)
    );

    for (genvar i = 0; i < NSLV; i++) begin : g_lane
        assign w_lane[i] = bus_rdata[lane_lsb(i, DW) +: DW];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            miss_q       <= 1'b0;
            write_q      <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_w_q      <= 1'b0;
            bus_sel_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_q   <= w_idx;
                        miss_q  <= w_miss;
                        write_q <= req_write;
                        // Bus is driven from the accept edge so it is valid throughout ADDR.
                        if (!w_miss) begin
                            bus_addr_q  <= req_addr;
                            bus_wdata_q <= req_wdata;
                            bus_w_q     <= req_write;
                            bus_sel_q   <= w_sel;
                        end
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (miss_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= c_ERR;
                        state_q      <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack[idx_q]) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= write_q ? '0 : w_lane[idx_q];
                        cnt_q        <= '0;
                        bus_addr_q   <= '0;
                        bus_wdata_q  <= '0;
                        bus_w_q      <= 1'b0;
                        bus_sel_q    <= '0;
                        state_q      <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (cnt_q == c_TO_LAST)) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= c_ERR;
                        cnt_q        <= '0;
                        bus_addr_q   <= '0;
                        bus_wdata_q  <= '0;
                        bus_w_q      <= 1'b0;
                        bus_sel_q    <= '0;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_w      = bus_w_q;
    assign bus_sel    = bus_sel_q;

endmodule
`default_nettype wire

// File: doc/syncbus_ctrl.md
Name: syncbus_ctrl

Overview:
Parametrised synchronous bus master controller, the next generation of our single-master/two-device sync bus. It accepts one request at a time from a host-side valid/ready port and decodes the address to one of NSLV slaves. It drives a shared address/write-data bus with one-hot selects, waits for the selected slave's ack through any number of wait states, and returns read data or an error. Separate read-data and ack lanes per slave replace the tri-state data bus, so the block is synthesis-clean.

Parameters:
AW, 16, address width
DW, 16, data width
NSLV, 2, number of slaves (1..16)
BASE, {16'hFFF8,16'hFFF0}, packed NSLV*AW base addresses; slave i uses BASE[i*AW +: AW]
DEC_MASK, 16'hFFF8, address bits compared during decode
TIMEOUT, 16, WAIT cycles before error; 0 disables timeout
ERR_DATA, 16'hDEAD, resp_rdata value on error (truncated or zero-extended to DW)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  AW  request address
req_wdata  in  DW  write data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DW  read data, or ERR_DATA on error
resp_err  out  1  decode miss or timeout
bus_addr  out  AW  shared address bus
bus_wdata  out  DW  shared write-data bus
bus_w  out  1  write strobe, qualified by bus_sel
bus_sel  out  NSLV  one-hot slave select
bus_rdata  in  NSLV*DW  per-slave read data, lane i = [i*DW +: DW]
bus_ack  in  NSLV  per-slave ack

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; bus_addr=0; bus_wdata=0; bus_w=0; bus_sel=0; timeout counter=0.
- FSM states are IDLE, ADDR, WAIT, RESP.
- IDLE:
  - req_ready=1, combinationally equal to (state==IDLE).
  - On req_valid at a clock edge, register addr, wdata, write and the decoded index, then go to ADDR.
  - All bus outputs are 0 while IDLE.
- Decode: slave i matches when (req_addr & DEC_MASK) == (BASE_i & DEC_MASK). If several slaves match, the lowest index wins. No match sets a miss flag.
- ADDR (exactly 1 cycle):
  - On a hit: drive bus_addr, bus_wdata, bus_w=req_write and bus_sel[idx]=1, then go to WAIT.
  - On a miss: bus_sel stays 0, then go to RESP with err=1.
- WAIT:
  - Bus outputs hold their ADDR values.
  - The ack is sampled only at edges in WAIT, and only bus_ack[idx] counts; acks from other slaves are ignored.
  - On ack: capture bus_rdata lane idx (reads only; writes capture 0), then go to RESP with err=0.
  - With no ack, the counter increments each WAIT cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with err=1.
- RESP (exactly 1 cycle):
  - resp_valid=1 and resp_err=err. resp_rdata is the captured data, or ERR_DATA when err=1.
  - Bus outputs return to 0 and the counter clears. Next state is IDLE.
  - There is no response backpressure.
- Latency: accept at edge E0, then ADDR, then WAIT from E1. A zero-wait ack sampled at E2 puts resp_valid high in the cycle after E2. Each wait state adds 1 cycle. A decode miss gives resp_valid in the cycle after E1.
- Timeout: with TIMEOUT=N, err resp_valid asserts in the cycle after the Nth WAIT edge without ack.
- resp_rdata holds its value after RESP until the next response. resp_valid and resp_err are 0 outside RESP.
- An ack arriving in the same WAIT edge that the timeout is reached takes priority: the transaction succeeds.
- Reset mid-transaction aborts it immediately: bus_sel drops asynchronously and no response is produced.
- bus_w is never 1 while bus_sel==0.

Decomposition:
- Package syncbus_pkg holds:
  - the state enum (IDLE/ADDR/WAIT/RESP);
  - default ERR_DATA;
  - a helper function for lane extraction.
- One sub-module, syncbus_decode: combinational, parametrised by AW/NSLV/BASE/DEC_MASK. Outputs are the index, one-hot select and miss flag.

Test Plan:
1. Read from FFF0 with slave0 acking in the first WAIT cycle and lane0=E3E3 -> bus_sel=01, bus_w=0, resp_valid in the cycle after E2, resp_rdata=E3E3, resp_err=0.
2. Write 71F0 to FFF8 with slave1 acking after 3 wait cycles -> bus_sel=10, bus_w=1, bus_wdata=71F0 held for 4 WAIT cycles, resp_err=0, req_ready low throughout.
3. Read from 0000 (no match) -> bus_sel never asserts, resp_valid in the cycle after E1, resp_err=1, resp_rdata=DEAD.
4. Read from FFF0 with no ack and TIMEOUT=16 -> exactly 16 WAIT cycles, then resp_err=1 and resp_rdata=DEAD. Repeat with the ack on the 16th edge -> success.
5. Slave1 acks spuriously during a slave0 transaction -> ignored, and the transaction completes on slave0's ack.
6. Assert reset_n=0 during WAIT -> bus_sel=0 immediately, no resp_valid, req_ready=1 after release. A following read of FFF0 behaves as in scenario 1.
